// File: rtl/bm_dl_digit_serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The master issues start/operands; the slave returns busy/done and the registered result.
interface bm_dl_digit_serial_subtractor_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              borrowin;
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] Y;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] D;
  logic              borrowout;
  logic              overflow;

  modport master (
    output start, borrowin, X, Y,
    input  busy, done, D, borrowout, overflow
  );

  modport slave (
    input  start, borrowin, X, Y,
    output busy, done, D, borrowout, overflow
  );
endinterface

// File: rtl/bm_dl_digit_serial_subtractor.sv
// Digit-serial subtractor: D = X - Y - borrowin, DIGIT_W bits per clock, low digit first.
// Subtraction is done as X + ~Y + c with c = ~borrow, so borrowout is the inverted final carry.
module bm_dl_digit_serial_subtractor #(
  parameter int DATA_W  = 32,
  parameter int DIGIT_W = 4
) (
  input logic                         clock,
  input logic                         reset,
  bm_dl_digit_serial_subtractor_if.slave bus
);

  localparam int DIGITS = DATA_W / DIGIT_W;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   xsh_q, xsh_d;
  logic [DATA_W-1:0]   ysh_q, ysh_d;
  logic [DATA_W-1:0]   dsh_q, dsh_d;
  logic                c_q, c_d;
  logic                xmsb_q, xmsb_d;
  logic                ymsb_q, ymsb_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                bo_q, bo_d;
  logic                ov_q, ov_d;
  logic                done_q, done_d;

  // Digit datapath: one (DIGIT_W+1)-bit add per cycle, carry kept in c_q.
  logic [DIGIT_W:0]          sum;
  logic [DIGIT_W-1:0]        dig;
  logic                      c_nxt;
  logic [DATA_W+DIGIT_W-1:0] dsh_cat;
  logic [DATA_W-1:0]         dsh_shift;
  logic                      last;

  always_comb begin
    sum       = {1'b0, xsh_q[DIGIT_W-1:0]} + {1'b0, ~ysh_q[DIGIT_W-1:0]}
              + (DIGIT_W+1)'(c_q);
    dig       = sum[DIGIT_W-1:0];
    c_nxt     = sum[DIGIT_W];
    dsh_cat   = {dig, dsh_q};
    dsh_shift = dsh_cat[DATA_W+DIGIT_W-1:DIGIT_W];
    last      = (cnt_q == CNT_W'(DIGITS - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xsh_d   = xsh_q;
    ysh_d   = ysh_q;
    dsh_d   = dsh_q;
    c_d     = c_q;
    xmsb_d  = xmsb_q;
    ymsb_d  = ymsb_q;
    res_d   = res_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          xsh_d   = bus.X;
          ysh_d   = bus.Y;
          xmsb_d  = bus.X[DATA_W-1];
          ymsb_d  = bus.Y[DATA_W-1];
          c_d     = ~bus.borrowin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        xsh_d = xsh_q >> DIGIT_W;
        ysh_d = ysh_q >> DIGIT_W;
        dsh_d = dsh_shift;
        c_d   = c_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          // Overflow only possible when operand signs differ and the result sign follows Y.
          res_d   = dsh_shift;
          bo_d    = ~c_nxt;
          ov_d    = (xmsb_q != ymsb_q) & (dig[DIGIT_W-1] != xmsb_q);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xsh_q   <= '0;
      ysh_q   <= '0;
      dsh_q   <= '0;
      c_q     <= 1'b0;
      xmsb_q  <= 1'b0;
      ymsb_q  <= 1'b0;
      res_q   <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xsh_q   <= xsh_d;
      ysh_q   <= ysh_d;
      dsh_q   <= dsh_d;
      c_q     <= c_d;
      xmsb_q  <= xmsb_d;
      ymsb_q  <= ymsb_d;
      res_q   <= res_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.D         = res_q;
  assign bus.borrowout = bo_q;
  assign bus.overflow  = ov_q;

endmodule
